param_sync_fifo: RTL
====================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter FIFO_WIDTH, default 8: data word width in bits; legal range 1..64.
REQ-002 Parameter FIFO_DEPTH, default 64: number of storage words; power of two, minimum 4.
REQ-003 Parameter AF_THRESH, default 56: almost_full asserts when count >= AF_THRESH; legal range 1..FIFO_DEPTH-1.
REQ-004 Parameter AE_THRESH, default 8: almost_empty asserts when count <= AE_THRESH; legal range 1..FIFO_DEPTH-1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  FIFO_WIDTH  write word.
REQ-009 full  output  1  count == FIFO_DEPTH.
REQ-010 almost_full  output  1  count >= AF_THRESH.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_data  output  FIFO_WIDTH  read word; timing per REQ-020 and REQ-032.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_empty  output  1  count <= AE_THRESH.
REQ-015 count  output  $clog2(FIFO_DEPTH)+1  number of stored words, 0..FIFO_DEPTH.
REQ-016 overflow  output  1  sticky flag: a write was dropped.
REQ-017 underflow  output  1  sticky flag: a read was refused.
REQ-018 err_clr  input  1  clears overflow and underflow.

Function
REQ-019 A write is accepted iff wr_en && !full; the word is stored at wr_ptr and wr_ptr increments modulo FIFO_DEPTH.
REQ-020 A read is accepted iff rd_en && !empty; rd_ptr increments modulo FIFO_DEPTH. In standard mode, rd_data is registered and shows the popped word one cycle after the accepted read; it holds its value otherwise.
REQ-021 Acceptance uses the full and empty values from before the clock edge. A write while full is dropped even if a read is accepted in the same cycle. A read while empty is refused even if a write is accepted in the same cycle.
REQ-022 count is registered: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
REQ-023 full, empty, almost_full and almost_empty are decoded combinationally from registered count only, so they change in the cycle after the causing edge.
REQ-024 Pointers wrap from FIFO_DEPTH-1 to 0 with no loss or duplication; FIFO order is preserved across any number of wraps.
REQ-025 overflow sets on wr_en && full; underflow sets on rd_en && empty; both stay set until rst or err_clr.
REQ-026 A set event wins over err_clr in the same cycle.
REQ-027 A dropped write or refused read changes no pointer, count or stored data.

Reset
REQ-028 rst (synchronous, active-high) forces on the next clock edge: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, overflow=0, underflow=0. As a result empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 rst has priority over wr_en, rd_en and err_clr in the same cycle.
REQ-030 Storage array contents are not reset. Data held before a mid-operation reset are unreachable after it.

Configuration
REQ-031 Macro FIFO_FWFT_EN selects first-word-fall-through read mode.
REQ-032 With FIFO_FWFT_EN defined, rd_data is combinationally mem[rd_ptr], is valid whenever empty==0, and advances to the next word in the cycle after an accepted read. rd_data is don't-care while empty.
REQ-033 Without FIFO_FWFT_EN, the standard registered read of REQ-020 applies. Flag and count behaviour is identical in both modes.

Verification
REQ-034 Reset then write 0x11..0x14, one per cycle -> count=4, empty=0, almost_empty=1; read 4 -> data 0x11..0x14 in order (standard mode: each one cycle after its rd_en); empty=1 afterwards.
REQ-035 Write 64 words with default parameters -> almost_full=1 when count reaches 56, full=1 at 64; 65th write -> count stays 64 and overflow=1; err_clr -> overflow=0.
REQ-036 When empty, assert rd_en and wr_en in the same cycle -> write accepted, read refused, underflow=1, count=1.
REQ-037 Hold count=32, then assert wr_en and rd_en together for 200 cycles with incrementing data -> count stays 32 every cycle and the read sequence matches the writes (crosses the pointer wrap 3 times).
REQ-038 Assert rst with count=20 -> next cycle count=0, empty=1, flags=0; a following write of 0xA5 then a read returns 0xA5.
REQ-039 With FIFO_FWFT_EN defined, write 0x3C into an empty FIFO -> next cycle empty=0 and rd_data=0x3C with no rd_en asserted.

Source files
------------

// File: rtl/param_sync_fifo_if.sv
// Handshake bundle for param_sync_fifo: write side, read side, status flags
// and error-clear. The master modport is the user of the FIFO; the slave
// modport is the FIFO itself. Parameters must match the connected FIFO.
interface param_sync_fifo_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 64
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  full, almost_full, rd_data, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output full, almost_full, rd_data, empty, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with registered occupancy count,
// count-decoded status flags and sticky overflow/underflow error flags.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through reads, where
// rd_data shows the head word combinationally; otherwise rd_data is a
// register loaded one cycle after each accepted read.
module param_sync_fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int AF_THRESH  = 56,
  parameter int AE_THRESH  = 8
) (
  input logic               clk,
  input logic               rst,
  param_sync_fifo_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come only from the registered count, so they lag the causing edge
  // by one cycle and acceptance always sees the pre-edge full/empty.
  assign full_w  = (count_q == CW'(FIFO_DEPTH));
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en && !full_w;
  assign rd_acc  = bus.rd_en && !empty_w;

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Storage is deliberately not reset; stale words become unreachable once
  // the pointers return to zero.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers are AW bits wide, so a power-of-two depth wraps for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy only moves when exactly one side is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error event in the same cycle beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w)  overflow_q <= 1'b1;
      else if (bus.err_clr)     overflow_q <= 1'b0;
      if (bus.rd_en && empty_w) underflow_q <= 1'b1;
      else if (bus.err_clr)     underflow_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; meaningless while the FIFO is empty.
  assign bus.rd_data = mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] rd_q;

  // Registered read: popped word appears one cycle after the accepted read
  // and holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_acc) begin
      rd_q <= mem[rd_ptr];
    end
  end

  assign bus.rd_data = rd_q;
`endif

endmodule
